// File: rtl/sw_key_input_pio.sv
// Switch/key input PIO: per-bit 2-flop sync, debounce, rising-edge capture,
// and an Avalon-MM slave exposing DATA / EDGE (W1C) / MASK / RAW with a level irq.
module sw_key_input_pio #(
    parameter int              N_IN            = 14,
    parameter int              DEBOUNCE_CYCLES = 250000,
    parameter logic [N_IN-1:0] INVERT_MASK     = 14'h3C00
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    input  logic [N_IN-1:0] pins_in,
    input  logic [1:0]      address,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_RAW  = 2'd3;

    logic [N_IN-1:0] raw, deb, rise;

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        logic          sync1_q, sync2_q;
        logic          deb_q, deb_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // Any disagreement shorter than DEBOUNCE_CYCLES clears the count, so it never wraps.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= pins_in[i] ^ INVERT_MASK[i];
                sync2_q <= sync1_q;
                deb_q   <= deb_d;
                cnt_q   <= cnt_d;
            end
        end

        assign raw[i]  = sync2_q;
        assign deb[i]  = deb_q;
        assign rise[i] = deb_d & ~deb_q;
    end

    logic [N_IN-1:0] edge_q, edge_d;
    logic [N_IN-1:0] mask_q, mask_d;
    logic [31:0]     readdata_q, readdata_d;

    // A new edge overrides a same-cycle W1C; reads see the pre-update registers.
    always_comb begin
        edge_d     = edge_q;
        mask_d     = mask_q;
        readdata_d = readdata_q;
        if (write && address == A_EDGE) edge_d = edge_q & ~writedata[N_IN-1:0];
        edge_d = edge_d | rise;
        if (write && address == A_MASK) mask_d = writedata[N_IN-1:0];
        if (read) begin
            readdata_d = '0;
            case (address)
                A_DATA:  readdata_d[N_IN-1:0] = deb;
                A_EDGE:  readdata_d[N_IN-1:0] = edge_q;
                A_MASK:  readdata_d[N_IN-1:0] = mask_q;
                A_RAW:   readdata_d[N_IN-1:0] = raw;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            edge_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

    if (N_IN < 32) begin : g_unused
        logic unused_wd;
        assign unused_wd = ^writedata[31:N_IN];
    end
endmodule

// File: tb/tb_sw_key_input_pio.sv
// Bench for sw_key_input_pio: register-map vector table, directed latency/corner
// sequences, and randomized traffic checked against a stable-window reference model.
module tb_sw_key_input_pio;
    localparam int          N   = 14;
    localparam int          DC  = 4;
    localparam logic [13:0] INV = 14'h3C00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] pins;
    logic [1:0]  address;
    logic        read, write;
    logic [31:0] writedata, readdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    sw_key_input_pio #(.N_IN(N), .DEBOUNCE_CYCLES(DC), .INVERT_MASK(INV)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .pins_in(pins), .address(address),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit is accepted once the synchronised level has sat at the
    // opposite value for DC consecutive cycles. hist[0] is the newest sample.
    logic [N-1:0] hist [0:DC+1];
    logic [N-1:0] m_deb, m_edge, m_mask, st_hi, st_lo, m_rise, m_clr;
    logic [31:0]  m_rd;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
            m_deb = '0; m_edge = '0; m_mask = '0; m_rd = '0;
        end else begin
            if (read) begin
                case (address)
                    2'd0: m_rd = {18'b0, m_deb};
                    2'd1: m_rd = {18'b0, m_edge};
                    2'd2: m_rd = {18'b0, m_mask};
                    default: m_rd = {18'b0, hist[1]};
                endcase
            end
            st_hi = '1; st_lo = '1;
            for (int k = 1; k <= DC; k++) begin
                st_hi = st_hi & hist[k];
                st_lo = st_lo & ~hist[k];
            end
            m_rise = st_hi & ~m_deb;
            m_deb  = (m_deb | st_hi) & ~st_lo;
            m_clr  = (write && address == 2'd1) ? writedata[N-1:0] : '0;
            m_edge = (m_edge & ~m_clr) | m_rise;
            if (write && address == 2'd2) m_mask = writedata[N-1:0];
            for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pins ^ INV;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_rd", readdata, m_rd);
            check("model_irq", {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1; write = 1'b0;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1; read = 1'b0;
        @(negedge clk);
        write = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        chk;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] d;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0,    1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h3FFF, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'h1234,      32'h0,    1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0,    1'b1};
        tbl[4]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF,      32'h0,    1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0,    1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF,      32'h0,    1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0,    1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 32'h00A5,      32'h3FFF, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h00A5, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h00A5, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h00A5, 1'b1};

        reset_n = 1'b0; pins = INV; address = 2'd0;
        read = 1'b0; write = 1'b0; writedata = '0;
        step(3);
        chk_on  = 1'b1;
        reset_n = 1'b1;

        // idle after reset: SW all off, KEY all released
        for (int i = 0; i < 20; i++) begin
            address = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd3;
            read = 1'b1;
            step(1);
            check("reset_idle", readdata, 32'h0);
            check("reset_irq", {31'b0, irq}, 32'h0);
        end
        read = 1'b0;

        for (int i = 0; i < 12; i++) begin
            address = tbl[i].addr; read = tbl[i].rd; write = tbl[i].wr; writedata = tbl[i].wd;
            step(1);
            if (tbl[i].chk) check($sformatf("tbl%0d", i), readdata, tbl[i].exp);
        end
        read = 1'b0; write = 1'b0;

        // SW[0] latency: RAW two edges after the change, DATA six
        pins[0] = 1'b1;
        read = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            address = (i <= 3) ? 2'd3 : 2'd0;
            step(1);
            if (i <= 3) check("raw_lat", {31'b0, readdata[0]}, {31'b0, i >= 3});
            else        check("data_lat", {31'b0, readdata[0]}, {31'b0, i >= 7});
        end
        read = 1'b0;
        bus_rd(2'd1, d); check("sw0_edge", d, 32'h001);
        check("sw0_irq", {31'b0, irq}, 32'h0);
        bus_wr(2'd1, 32'h3FFF);

        // SW[3] bounce: 1 for 3, 0 for 1, then held
        address = 2'd0; read = 1'b1;
        pins[3] = 1'b1; step(1); check("bounce_a", {31'b0, readdata[3]}, 32'h0);
        step(1);        check("bounce_b", {31'b0, readdata[3]}, 32'h0);
        step(1);        check("bounce_c", {31'b0, readdata[3]}, 32'h0);
        pins[3] = 1'b0; step(1); check("bounce_d", {31'b0, readdata[3]}, 32'h0);
        pins[3] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check("bounce_data", {31'b0, readdata[3]}, {31'b0, i >= 7});
        end
        read = 1'b0;
        step(8);
        bus_rd(2'd1, d); check("bounce_edge", d, 32'h008);

        // KEY[2] press with mask, W1C, release
        bus_wr(2'd1, 32'h3FFF);
        bus_wr(2'd2, 32'h3C00);
        pins[12] = 1'b0;
        step(8);
        bus_rd(2'd1, d); check("key_edge", d, 32'h1000);
        check("key_irq", {31'b0, irq}, 32'h1);
        bus_wr(2'd1, 32'h1000);
        bus_rd(2'd1, d); check("key_w1c", d, 32'h0);
        check("key_irq_clr", {31'b0, irq}, 32'h0);
        pins[12] = 1'b1;
        step(10);
        bus_rd(2'd1, d); check("key_release", d, 32'h0);
        check("key_rel_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd0, d); check("key_data", d, 32'h009);
        bus_wr(2'd2, 32'h0);

        // W1C collides with SW[5] rising: set wins, same-cycle read sees old value
        pins[5] = 1'b1;
        step(5);
        address = 2'd1; read = 1'b1; write = 1'b1; writedata = 32'h20;
        step(1);
        read = 1'b0; write = 1'b0;
        check("w1c_rd_pre", {31'b0, readdata[5]}, 32'h0);
        bus_rd(2'd1, d); check("w1c_set_wins", d, 32'h020);
        bus_wr(2'd1, 32'h3FFF);

        // reset while SW[1] counter is at 2; held inputs re-rise after release
        pins[1] = 1'b1;
        step(4);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        address = 2'd0; read = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("rst_mid_data", {31'b0, readdata[1]}, {31'b0, i >= 7});
        end
        read = 1'b0;
        bus_rd(2'd1, d); check("rst_mid_edge", d, 32'h02B);
        bus_rd(2'd2, d); check("rst_mid_mask", d, 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, N - 1);
                pins[b] = ~pins[b];
            end
            read      = 1'($urandom_range(0, 1));
            write     = ($urandom_range(0, 3) == 0);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            reset_n   = ($urandom_range(0, 599) != 0);
            step(1);
        end
        reset_n = 1'b1; read = 1'b0; write = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
